// File: rtl/pipe_scheduler.sv
// -----------------------------------------------------------------------------
// pipe_scheduler
//
// Sequences the pipe-scrolling datapath of the Flappy Bird LED-matrix game.
// On every scroll tick while a game is running it produces the next column to
// inject at the right edge of the display, and a one-cycle strobe telling the
// column shifter to advance and load that column. Pipes are PIPE_W columns
// wide with a GAP-row opening at a pseudo-random height, followed by SPACING
// empty columns. Every completed pipe period bumps the (saturating) score.
//
// Ports:
//   clk        in   1     system clock
//   reset      in   1     asynchronous, active-high reset
//   start      in   1     level; begin or restart a game (ignored while running)
//   gameover   in   1     level; collision detected, freeze scrolling
//   tick       in   1     one-cycle scroll-rate strobe from the rate divider
//   pipeRight  out  ROWS  column pattern for the shifter, bit i = row i, 1 = lit
//   shiftEn    out  1     one-cycle strobe: shifter advances and loads pipeRight
//   score      out  8     pipes emitted this game, saturating at 255
//   running    out  1     high while a game is scrolling
//
// All outputs come straight from flops; a tick sampled on one edge shows up
// on shiftEn/pipeRight right after that edge, for exactly one cycle.
// -----------------------------------------------------------------------------
module pipe_scheduler #(
    parameter int          ROWS    = 16,
    parameter int          GAP     = 4,
    parameter int          PIPE_W  = 2,
    parameter int          SPACING = 6,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            gameover,
    input  logic            tick,
    output logic [ROWS-1:0] pipeRight,
    output logic            shiftEn,
    output logic [7:0]      score,
    output logic            running
);

    localparam int PERIOD = PIPE_W + SPACING;
    localparam int CNT_W  = $clog2(PERIOD + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    // Highest legal gap top row, and the offset folding 13..15 back to 0..2.
    localparam logic [3:0] GAP_MAX  = 4'(ROWS - GAP);
    localparam logic [3:0] GAP_WRAP = 4'(ROWS - GAP + 1);

    localparam logic [CNT_W-1:0] PIPE_COLS = CNT_W'(PIPE_W);
    localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(PERIOD - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One Galois step of the x^8+x^6+x^5+x^4+1 LFSR (taps 8'hB8).
    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        logic [7:0] nxt;
        nxt = {1'b0, v[7:1]};
        if (v[0]) begin
            nxt = nxt ^ 8'hB8;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Map an LFSR value to a gap top row in 0..ROWS-GAP; out-of-range nibbles
    // fold back to the bottom so every gap fits fully on the display.
    function automatic logic [3:0] mapGap(input logic [7:0] v);
        logic [3:0] r;
        logic [3:0] result;
        r = v[3:0];
        if (r <= GAP_MAX) begin
            result = r;
        end else begin
            result = r - GAP_WRAP;
        end
        return result;
    endfunction

    // Solid column with GAP clear rows starting at row top.
    function automatic logic [ROWS-1:0] pipePattern(input logic [3:0] top);
        logic [ROWS-1:0] p;
        int              t;
        t = int'(top);
        for (int i = 0; i < ROWS; i++) begin
            p[i] = !((i >= t) && (i < t + GAP));
        end
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_r;
    logic [CNT_W-1:0] colCnt_r;
    logic [7:0]       lfsr_r;
    logic [3:0]       gapTop_r;
    logic [ROWS-1:0]  pipeRight_r;
    logic             shiftEn_r;
    logic [7:0]       score_r;
    logic             running_r;

    logic [1:0]       stateNext_s;
    logic [CNT_W-1:0] colCntNext_s;
    logic [7:0]       lfsrNext_s;
    logic [7:0]       lfsrStepped_s;
    logic [3:0]       gapTopNext_s;
    logic [ROWS-1:0]  pipeRightNext_s;
    logic             shiftEnNext_s;
    logic [7:0]       scoreNext_s;
    logic             runningNext_s;

    // Next-state and next-output logic for the IDLE/RUN/OVER sequencer.
    always_comb begin
        stateNext_s     = state_r;
        colCntNext_s    = colCnt_r;
        lfsrNext_s      = lfsr_r;
        gapTopNext_s    = gapTop_r;
        pipeRightNext_s = pipeRight_r;
        shiftEnNext_s   = 1'b0;
        scoreNext_s     = score_r;
        lfsrStepped_s   = lfsrStep(lfsr_r);

        case (state_r)
            IDLE, OVER: begin
                // The LFSR is deliberately not re-seeded here, so a restart
                // from OVER plays a different pipe sequence.
                if (start) begin
                    stateNext_s  = RUN;
                    colCntNext_s = '0;
                    scoreNext_s  = 8'd0;
                    gapTopNext_s = mapGap(lfsr_r);
                end else begin
                    stateNext_s  = state_r;
                end
            end

            RUN: begin
                // A collision wins over a simultaneous tick: nothing advances.
                if (gameover) begin
                    stateNext_s = OVER;
                end else if (tick) begin
                    shiftEnNext_s = 1'b1;
                    if (colCnt_r < PIPE_COLS) begin
                        pipeRightNext_s = pipePattern(gapTop_r);
                    end else begin
                        pipeRightNext_s = '0;
                    end
                    // End of a pipe period: pick the next gap and score it.
                    if (colCnt_r == LAST_COL) begin
                        colCntNext_s = '0;
                        lfsrNext_s   = lfsrStepped_s;
                        gapTopNext_s = mapGap(lfsrStepped_s);
                        if (score_r == 8'hFF) begin
                            scoreNext_s = score_r;
                        end else begin
                            scoreNext_s = score_r + 8'd1;
                        end
                    end else begin
                        colCntNext_s = colCnt_r + CNT_W'(1);
                    end
                end else begin
                    shiftEnNext_s = 1'b0;
                end
            end

            default: begin
                stateNext_s = IDLE;
            end
        endcase

        runningNext_s = (stateNext_s == RUN);
    end

    // Sequencer state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            colCnt_r    <= '0;
            lfsr_r      <= SEED;
            gapTop_r    <= 4'd0;
            pipeRight_r <= '0;
            shiftEn_r   <= 1'b0;
            score_r     <= 8'd0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            colCnt_r    <= colCntNext_s;
            lfsr_r      <= lfsrNext_s;
            gapTop_r    <= gapTopNext_s;
            pipeRight_r <= pipeRightNext_s;
            shiftEn_r   <= shiftEnNext_s;
            score_r     <= scoreNext_s;
            running_r   <= runningNext_s;
        end
    end

    assign pipeRight = pipeRight_r;
    assign shiftEn   = shiftEn_r;
    assign score     = score_r;
    assign running   = running_r;

endmodule

// File: tb/tb_pipe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pipe_scheduler
//
// Directed self-checking bench for pipe_scheduler. Inputs change on the
// falling edge, outputs are sampled on the falling edge after the rising edge
// that registered them. Expected gap heights for the first 26 pipes from
// seed 8'hA5 are a hand-computed table.
// -----------------------------------------------------------------------------
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        gameover;
    logic        tick;
    logic [15:0] pipeRight;
    logic        shiftEn;
    logic [7:0]  score;
    logic        running;

    int numChecks = 0;
    int numErrors = 0;

    // Gap top row of pipe k, walking the LFSR from A5 by hand.
    logic [3:0] gapTab [0:25] = '{4'd5, 4'd10, 4'd5, 4'd2, 4'd1, 4'd8, 4'd12,
                                  4'd6, 4'd3, 4'd1, 4'd0, 4'd0, 4'd8, 4'd12,
                                  4'd1, 4'd7, 4'd11, 4'd5, 4'd10, 4'd5, 4'd10,
                                  4'd5, 4'd10, 4'd0, 4'd1, 4'd2};

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .gameover  (gameover),
        .tick      (tick),
        .pipeRight (pipeRight),
        .shiftEn   (shiftEn),
        .score     (score),
        .running   (running)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] patOf(input logic [3:0] g);
        logic [15:0] m;
        m = 16'h000F;
        return ~(m << g);
    endfunction

    // Exactly four zero bits, and they are contiguous.
    function automatic logic gapOk(input logic [15:0] v);
        int zeros;
        int first;
        zeros = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            if (!v[i]) begin
                zeros++;
                if (first < 0) first = i;
            end
        end
        if (zeros != 4 || first < 0 || first > 12) return 1'b0;
        return (v[first +: 4] == 4'b0000);
    endfunction

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One isolated tick; strobe must be low before and high after.
    task automatic doTick(input string tag, input logic [15:0] exp);
        @(negedge clk);
        checkEq({tag, "/pre"}, {31'd0, shiftEn}, 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checkEq({tag, "/se"}, {31'd0, shiftEn}, 32'd1);
        checkEq({tag, "/pat"}, {16'd0, pipeRight}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] col0;

        reset = 1'b1; start = 1'b0; gameover = 1'b0; tick = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("rst/pat", {16'd0, pipeRight}, 32'd0);
        checkEq("rst/se", {31'd0, shiftEn}, 32'd0);
        checkEq("rst/score", {24'd0, score}, 32'd0);
        checkEq("rst/run", {31'd0, running}, 32'd0);
        reset = 1'b0;

        // IDLE ignores tick.
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        checkEq("idle/se", {31'd0, shiftEn}, 32'd0);
        checkEq("idle/run", {31'd0, running}, 32'd0);

        // Test 1: start, first tick gives the seed pattern.
        pulseStart();
        checkEq("start/run", {31'd0, running}, 32'd1);
        checkEq("start/score", {24'd0, score}, 32'd0);
        doTick("t1", 16'hFE1F);

        // Test 2: rest of the first period.
        doTick("t2c1", 16'hFE1F);
        for (int i = 2; i < 7; i++) doTick("t2zero", 16'h0000);
        checkEq("t2/score7", {24'd0, score}, 32'd0);
        doTick("t2c7", 16'h0000);
        checkEq("t2/score8", {24'd0, score}, 32'd1);

        // start while running is ignored.
        pulseStart();
        checkEq("runstart/score", {24'd0, score}, 32'd1);
        checkEq("runstart/run", {31'd0, running}, 32'd1);
        doTick("t2_9th", 16'hC3FF);
        doTick("t2_10th", 16'hC3FF);

        // Test 3: gameover beats a simultaneous tick; next column would be 0.
        @(negedge clk) begin tick = 1'b1; gameover = 1'b1; end
        @(negedge clk) begin tick = 1'b0; gameover = 1'b0; end
        checkEq("go/se", {31'd0, shiftEn}, 32'd0);
        checkEq("go/run", {31'd0, running}, 32'd0);
        checkEq("go/pat", {16'd0, pipeRight}, 32'h0000C3FF);
        checkEq("go/score", {24'd0, score}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            checkEq("over/se", {31'd0, shiftEn}, 32'd0);
            checkEq("over/pat", {16'd0, pipeRight}, 32'h0000C3FF);
        end

        // Test 4: restart from OVER continues from lfsr EA, not the seed.
        pulseStart();
        checkEq("restart/run", {31'd0, running}, 32'd1);
        checkEq("restart/score", {24'd0, score}, 32'd0);
        doTick("restart/c0", 16'hC3FF);
        // Back-to-back ticks are each serviced.
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        checkEq("b2b/se1", {31'd0, shiftEn}, 32'd1);
        checkEq("b2b/pat1", {16'd0, pipeRight}, 32'h0000C3FF);
        @(negedge clk) tick = 1'b0;
        checkEq("b2b/se2", {31'd0, shiftEn}, 32'd1);
        checkEq("b2b/pat2", {16'd0, pipeRight}, 32'd0);
        for (int i = 3; i < 8; i++) doTick("restart/zero", 16'h0000);
        checkEq("restart/score1", {24'd0, score}, 32'd1);

        // Test 5: walk pipes 2..25, covering nibbles 13, 14, 15.
        for (int k = 2; k < 26; k++) begin
            doTick("walk/c0", patOf(gapTab[k]));
            col0 = pipeRight;
            checkEq("walk/gapok", {31'd0, gapOk(col0)}, 32'd1);
            if (k == 23) checkEq("nib13", {16'd0, col0}, 32'h0000FFF0);
            if (k == 24) checkEq("nib14", {16'd0, col0}, 32'h0000FFE1);
            if (k == 25) checkEq("nib15", {16'd0, col0}, 32'h0000FFC3);
            doTick("walk/c1", patOf(gapTab[k]));
            for (int c = 2; c < 8; c++) doTick("walk/zero", 16'h0000);
        end
        checkEq("walk/score", {24'd0, score}, 32'd25);

        // Test 6: async reset mid-run with tick active.
        doTick("pre_rst", 16'hFFC3);
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        checkEq("pre_rst/se", {31'd0, shiftEn}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkEq("arst/pat", {16'd0, pipeRight}, 32'd0);
        checkEq("arst/se", {31'd0, shiftEn}, 32'd0);
        checkEq("arst/score", {24'd0, score}, 32'd0);
        checkEq("arst/run", {31'd0, running}, 32'd0);
        @(negedge clk) begin reset = 1'b0; tick = 1'b0; end
        pulseStart();
        doTick("reseed", 16'hFE1F);

        // Saturation: continuous ticks, 8 per pipe.
        @(negedge clk) tick = 1'b1;
        repeat (1599) @(negedge clk);
        checkEq("sat/score200", {24'd0, score}, 32'd200);
        repeat (800) @(negedge clk);
        tick = 1'b0;
        checkEq("sat/score255", {24'd0, score}, 32'd255);
        checkEq("sat/run", {31'd0, running}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
